// File: rtl/rf_exec_ctrl.sv
// rf_exec_ctrl: execute/writeback sequencer for an 8x16 register file.
// Optional macro ALU_MUL_EN enables the 16-cycle shift-add MUL on op 111.
module rf_exec_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 8
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic [ADDR_W-1:0] Addr_A,
    output logic [ADDR_W-1:0] Addr_B,
    output logic              WR,
    output logic [DATA_W-1:0] Data_in,
    input  logic [DATA_W-1:0] Src,
    input  logic [DATA_W-1:0] Dest
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        WB
    } state_t;

    state_t state, state_d;

    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_a_d, addr_b_d;
    logic              busy_d, done_d, err_d, wr_d;
    logic [DATA_W-1:0] data_d;
    logic              fz_d, fc_d, fv_d;

    logic              bad_addr;
    logic              bad_op;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                alu_v;
    logic [DATA_W:0]     add_w;
    logic [DATA_W:0]     sub_w;
    logic [2*DATA_W-1:0] shl_w;

    assign bad_addr = ({1'b0, ra} >= (ADDR_W+1)'(NUM_REGS))
                   || ({1'b0, rb} >= (ADDR_W+1)'(NUM_REGS));

`ifdef ALU_MUL_EN
    logic [3:0]          cnt, cnt_d;
    logic [2*DATA_W-1:0] acc, acc_d;
    logic [2*DATA_W-1:0] acc_nxt;
    logic [2*DATA_W-1:0] pp;

    assign bad_op = 1'b0;

    // One partial product per EXEC cycle; Src/Dest stay stable while busy
    always_comb begin
        pp = '0;
        if (Src[cnt]) begin
            pp = {{DATA_W{1'b0}}, Dest} << cnt;
        end
        acc_nxt = acc + pp;
    end
`else
    assign bad_op = (op == OP_MUL);
`endif

    assign add_w = {1'b0, Dest} + {1'b0, Src};
    assign sub_w = {1'b0, Dest} - {1'b0, Src};
    assign shl_w = {{DATA_W{1'b0}}, Dest} << Src[3:0];

    // Single-cycle ALU: result plus carry/overflow for the latched op
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = add_w[DATA_W-1:0];
                alu_c   = add_w[DATA_W];
                alu_v   = (Dest[DATA_W-1] == Src[DATA_W-1])
                       && (add_w[DATA_W-1] != Dest[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[DATA_W-1:0];
                alu_c   = (Dest < Src);
                alu_v   = (Dest[DATA_W-1] != Src[DATA_W-1])
                       && (sub_w[DATA_W-1] != Dest[DATA_W-1]);
            end
            OP_AND: alu_res = Dest & Src;
            OP_OR:  alu_res = Dest | Src;
            OP_XOR: alu_res = Dest ^ Src;
            OP_SHL: begin
                alu_res = shl_w[DATA_W-1:0];
                alu_c   = shl_w[DATA_W];
            end
            OP_MOV: alu_res = Src;
            default: begin
                alu_res = '0;
            end
        endcase
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_d  = state;
        op_d     = op_q;
        addr_a_d = Addr_A;
        addr_b_d = Addr_B;
        busy_d   = busy;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_d     = 1'b0;
        data_d   = Data_in;
        fz_d     = flag_z;
        fc_d     = flag_c;
        fv_d     = flag_v;
`ifdef ALU_MUL_EN
        cnt_d    = cnt;
        acc_d    = acc;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    addr_a_d = ra;
                    addr_b_d = rb;
                    if (bad_addr || bad_op) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        busy_d  = 1'b1;
`ifdef ALU_MUL_EN
                        cnt_d   = 4'd0;
                        acc_d   = '0;
`endif
                    end
                end
            end
            FETCH: begin
                state_d = EXEC;
            end
            EXEC: begin
`ifdef ALU_MUL_EN
                if (op_q == OP_MUL) begin
                    acc_d = acc_nxt;
                    cnt_d = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state_d = WB;
                        wr_d    = 1'b1;
                        data_d  = acc_nxt[DATA_W-1:0];
                        fz_d    = (acc_nxt[DATA_W-1:0] == '0);
                        fc_d    = (acc_nxt[2*DATA_W-1:DATA_W] != '0);
                        fv_d    = 1'b0;
                    end
                end else begin
                    state_d = WB;
                    wr_d    = 1'b1;
                    data_d  = alu_res;
                    fz_d    = (alu_res == '0);
                    fc_d    = alu_c;
                    fv_d    = alu_v;
                end
`else
                state_d = WB;
                wr_d    = 1'b1;
                data_d  = alu_res;
                fz_d    = (alu_res == '0);
                fc_d    = alu_c;
                fv_d    = alu_v;
`endif
            end
            WB: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight write
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            op_q    <= 3'b000;
            Addr_A  <= '0;
            Addr_B  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            WR      <= 1'b0;
            Data_in <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
        end else begin
            state   <= state_d;
            op_q    <= op_d;
            Addr_A  <= addr_a_d;
            Addr_B  <= addr_b_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            WR      <= wr_d;
            Data_in <= data_d;
            flag_z  <= fz_d;
            flag_c  <= fc_d;
            flag_v  <= fv_d;
        end
    end

`ifdef ALU_MUL_EN
    // Multiplier step counter and product accumulator
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt <= 4'd0;
            acc <= '0;
        end else begin
            cnt <= cnt_d;
            acc <= acc_d;
        end
    end
`endif

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// tb_rf_exec_ctrl: directed bench for rf_exec_ctrl with a register file model.
// Register file: 8x16, registered reads, write on WR.
module tb_rf_exec_ctrl;

    logic        CLK;
    logic        RSTn;
    logic        start;
    logic [2:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        busy;
    logic        done;
    logic        err;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;
    logic [3:0]  Addr_A;
    logic [3:0]  Addr_B;
    logic        WR;
    logic [15:0] Data_in;
    logic [15:0] Src;
    logic [15:0] Dest;

    logic        rf_load;
    logic [15:0] rf [8];

    int n_cmp;
    int n_bad;

    rf_exec_ctrl dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .start   (start),
        .op      (op),
        .ra      (ra),
        .rb      (rb),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .flag_v  (flag_v),
        .Addr_A  (Addr_A),
        .Addr_B  (Addr_B),
        .WR      (WR),
        .Data_in (Data_in),
        .Src     (Src),
        .Dest    (Dest)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file model: registered read ports, write port on B
    always @(posedge CLK) begin
        if (rf_load) begin
            rf[0] <= 16'h0000;
            rf[1] <= 16'h7FFF;
            rf[2] <= 16'h0001;
            rf[3] <= 16'h0005;
            rf[4] <= 16'h0005;
            rf[5] <= 16'h0003;
            rf[6] <= 16'h0100;
            rf[7] <= 16'h0100;
            Src   <= 16'h0000;
            Dest  <= 16'h0000;
        end else begin
            Src  <= Addr_A[3] ? 16'h0000 : rf[Addr_A[2:0]];
            Dest <= Addr_B[3] ? 16'h0000 : rf[Addr_B[2:0]];
            if (WR && !Addr_B[3]) begin
                rf[Addr_B[2:0]] <= Data_in;
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [3:0] a,
                         input logic [3:0] b);
        start = 1'b1;
        op    = o;
        ra    = a;
        rb    = b;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int lat, output int wrs,
                             output logic [15:0] wdata,
                             output logic [3:0] waddr, output int bcnt);
        int n;
        n     = n0;
        lat   = -1;
        wrs   = 0;
        wdata = 16'h0;
        waddr = 4'h0;
        bcnt  = 0;
        while (n <= 40) begin
            if (busy) bcnt++;
            if (WR) begin
                wrs++;
                wdata = Data_in;
                waddr = Addr_B;
            end
            if (done) begin
                lat = n;
                break;
            end
            @(posedge CLK);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        RSTn    = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        ra      = 4'h0;
        rb      = 4'h0;
        rf_load = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++; if ({busy, done, err, WR} !== 4'b0000) begin n_bad++; $display("FAIL reset_ctl got %b want 0000", {busy, done, err, WR}); end
        n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {flag_z, flag_c, flag_v}); end
        n_cmp++; if ({Addr_A, Addr_B, Data_in} !== 24'h0) begin n_bad++; $display("FAIL reset_bus got %h want 000000", {Addr_A, Addr_B, Data_in}); end
        rf_load = 1'b0;
        RSTn    = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_add();
        int lat, wrs, bc;
        logic [15:0] wd;
        logic [3:0]  wa;
        issue(3'b000, 4'd2, 4'd1);
        wait_done(0, lat, wrs, wd, wa, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL add_latency got %0d want 3", lat); end
        n_cmp++; if (bc !== 3) begin n_bad++; $display("FAIL add_busy_cycles got %0d want 3", bc); end
        n_cmp++; if (wrs !== 1) begin n_bad++; $display("FAIL add_wr_cycles got %0d want 1", wrs); end
        n_cmp++; if (wa !== 4'd1) begin n_bad++; $display("FAIL add_wr_addr got %0d want 1", wa); end
        n_cmp++; if (wd !== 16'h8000) begin n_bad++; $display("FAIL add_data got %h want 8000", wd); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL add_err got %b want 0", err); end
        n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b001) begin n_bad++; $display("FAIL add_flags got %b want 001", {flag_z, flag_c, flag_v}); end
        @(posedge CLK);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL add_done_pulse got %b want 0", done); end
    endtask

    task automatic test_sub();
        int lat, wrs, bc;
        logic [15:0] wd;
        logic [3:0]  wa;
        issue(3'b001, 4'd4, 4'd3);
        wait_done(0, lat, wrs, wd, wa, bc);
        n_cmp++; if (wd !== 16'h0000) begin n_bad++; $display("FAIL sub_eq_data got %h want 0000", wd); end
        n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b100) begin n_bad++; $display("FAIL sub_eq_flags got %b want 100", {flag_z, flag_c, flag_v}); end
        issue(3'b001, 4'd4, 4'd5);
        wait_done(0, lat, wrs, wd, wa, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sub_neg_latency got %0d want 3", lat); end
        n_cmp++; if (wd !== 16'hFFFE) begin n_bad++; $display("FAIL sub_neg_data got %h want fffe", wd); end
        n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b010) begin n_bad++; $display("FAIL sub_neg_flags got %b want 010", {flag_z, flag_c, flag_v}); end
    endtask

    task automatic test_logic();
        logic [2:0]  t_op [7] = '{3'b010, 3'b011, 3'b100, 3'b101,
                                  3'b110, 3'b101, 3'b000};
        logic [3:0]  t_ra [7] = '{4'd4, 4'd2, 4'd4, 4'd2, 4'd6, 4'd4, 4'd2};
        logic [3:0]  t_rb [7] = '{4'd5, 4'd3, 4'd4, 4'd1, 4'd0, 4'd6, 4'd2};
        logic [15:0] t_d  [7] = '{16'h0004, 16'h0001, 16'h0000, 16'h0000,
                                  16'h0100, 16'h0100, 16'h0002};
        logic [2:0]  t_f  [7] = '{3'b000, 3'b000, 3'b100, 3'b110,
                                  3'b000, 3'b000, 3'b000};
        int lat, wrs, bc;
        logic [15:0] wd;
        logic [3:0]  wa;
        for (int i = 0; i < 7; i++) begin
            issue(t_op[i], t_ra[i], t_rb[i]);
            wait_done(0, lat, wrs, wd, wa, bc);
            n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL logic%0d_latency got %0d want 3", i, lat); end
            n_cmp++; if (wrs !== 1 || wa !== t_rb[i]) begin n_bad++; $display("FAIL logic%0d_wr got %0d@%0d want 1@%0d", i, wrs, wa, t_rb[i]); end
            n_cmp++; if (wd !== t_d[i]) begin n_bad++; $display("FAIL logic%0d_data got %h want %h", i, wd, t_d[i]); end
            n_cmp++; if ({flag_z, flag_c, flag_v} !== t_f[i]) begin n_bad++; $display("FAIL logic%0d_flags got %b want %b", i, {flag_z, flag_c, flag_v}, t_f[i]); end
        end
    endtask

    task automatic test_mul();
        int lat, wrs, bc;
        logic [15:0] wd;
        logic [3:0]  wa;
        issue(3'b111, 4'd7, 4'd6);
        wait_done(0, lat, wrs, wd, wa, bc);
`ifdef ALU_MUL_EN
        n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL mul_latency got %0d want 18", lat); end
        n_cmp++; if (wrs !== 1 || wa !== 4'd6) begin n_bad++; $display("FAIL mul_wr got %0d@%0d want 1@6", wrs, wa); end
        n_cmp++; if (wd !== 16'h0000) begin n_bad++; $display("FAIL mul_data got %h want 0000", wd); end
        n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b110) begin n_bad++; $display("FAIL mul_flags got %b want 110", {flag_z, flag_c, flag_v}); end
        issue(3'b111, 4'd2, 4'd0);
        wait_done(0, lat, wrs, wd, wa, bc);
        n_cmp++; if (wd !== 16'h0200) begin n_bad++; $display("FAIL mul2_data got %h want 0200", wd); end
        n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b000) begin n_bad++; $display("FAIL mul2_flags got %b want 000", {flag_z, flag_c, flag_v}); end
`else
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL mul_off_latency got %0d want 0", lat); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mul_off_err got %b want 1", err); end
        n_cmp++; if (wrs !== 0) begin n_bad++; $display("FAIL mul_off_wr got %0d want 0", wrs); end
        n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b000) begin n_bad++; $display("FAIL mul_off_flags got %b want 000", {flag_z, flag_c, flag_v}); end
`endif
    endtask

    task automatic test_illegal();
        int lat, wrs, bc;
        logic [15:0] wd;
        logic [3:0]  wa;
        issue(3'b001, 4'd2, 4'd3);
        wait_done(0, lat, wrs, wd, wa, bc);
        n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b010) begin n_bad++; $display("FAIL ill_pre_flags got %b want 010", {flag_z, flag_c, flag_v}); end
        issue(3'b000, 4'b1000, 4'd1);
        n_cmp++; if ({done, err, busy} !== 3'b110) begin n_bad++; $display("FAIL ill_ra_status got %b want 110", {done, err, busy}); end
        n_cmp++; if (Addr_A !== 4'b1000) begin n_bad++; $display("FAIL ill_ra_addr got %h want 8", Addr_A); end
        wait_done(0, lat, wrs, wd, wa, bc);
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (WR) wrs++;
        end
        n_cmp++; if (wrs !== 0) begin n_bad++; $display("FAIL ill_ra_wr got %0d want 0", wrs); end
        issue(3'b000, 4'd1, 4'b1111);
        wait_done(0, lat, wrs, wd, wa, bc);
        n_cmp++; if (lat !== 0 || err !== 1'b1) begin n_bad++; $display("FAIL ill_rb got lat %0d err %b want 0 1", lat, err); end
        n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b010) begin n_bad++; $display("FAIL ill_flags_hold got %b want 010", {flag_z, flag_c, flag_v}); end
        @(posedge CLK);
        #1;
        n_cmp++; if ({done, err, WR} !== 3'b000) begin n_bad++; $display("FAIL ill_after got %b want 000", {done, err, WR}); end
    endtask

    task automatic test_ignore();
        int lat, wrs, bc, extra;
        logic [15:0] wd;
        logic [3:0]  wa;
        issue(3'b000, 4'd2, 4'd5);
        start = 1'b1;
        op    = 3'b000;
        ra    = 4'd1;
        rb    = 4'd1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        wait_done(2, lat, wrs, wd, wa, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL ign_latency got %0d want 3", lat); end
        n_cmp++; if (wd !== 16'h0006 || wa !== 4'd5) begin n_bad++; $display("FAIL ign_write got %h@%0d want 0006@5", wd, wa); end
        extra = 0;
        repeat (5) begin
            @(posedge CLK);
            #1;
            if (WR || done || busy) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ign_no_replay got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat, wrs, bc;
        logic [15:0] wd;
        logic [3:0]  wa;
        issue(3'b000, 4'd2, 4'd3);
        wait_done(0, lat, wrs, wd, wa, bc);
        n_cmp++; if (wd !== 16'h0001 || {flag_z, flag_c, flag_v} !== 3'b010) begin n_bad++; $display("FAIL b2b_first got %h/%b want 0001/010", wd, {flag_z, flag_c, flag_v}); end
        issue(3'b001, 4'd3, 4'd2);
        wait_done(0, lat, wrs, wd, wa, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b2b_latency got %0d want 3", lat); end
        n_cmp++; if (wd !== 16'h0001) begin n_bad++; $display("FAIL b2b_data got %h want 0001", wd); end
        n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b000) begin n_bad++; $display("FAIL b2b_flags got %b want 000", {flag_z, flag_c, flag_v}); end
    endtask

    task automatic test_rst_mid();
        int lat, wrs, bc;
        logic [15:0] wd;
        logic [3:0]  wa;
        issue(3'b001, 4'd2, 4'd4);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        n_cmp++; if ({WR, busy, flag_c} !== 3'b111) begin n_bad++; $display("FAIL rst_pre got %b want 111", {WR, busy, flag_c}); end
        #3;
        RSTn = 1'b0;
        #1;
        n_cmp++; if ({WR, busy, done, flag_z, flag_c, flag_v} !== 6'b0) begin n_bad++; $display("FAIL rst_wb_drop got %b want 000000", {WR, busy, done, flag_z, flag_c, flag_v}); end
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        issue(3'b000, 4'd2, 4'd4);
        wait_done(0, lat, wrs, wd, wa, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rst_restart_latency got %0d want 3", lat); end
        n_cmp++; if (wd !== 16'h0001) begin n_bad++; $display("FAIL rst_no_write got %h want 0001", wd); end
`ifdef ALU_MUL_EN
        issue(3'b001, 4'd2, 4'd4);
        wait_done(0, lat, wrs, wd, wa, bc);
        issue(3'b111, 4'd7, 4'd6);
        for (int i = 0; i < 7; i++) begin
            @(posedge CLK);
            #1;
        end
        n_cmp++; if ({busy, flag_z} !== 2'b11) begin n_bad++; $display("FAIL rst_mul_pre got %b want 11", {busy, flag_z}); end
        #3;
        RSTn = 1'b0;
        #1;
        n_cmp++; if ({WR, busy, done, flag_z, flag_c, flag_v} !== 6'b0) begin n_bad++; $display("FAIL rst_mul_drop got %b want 000000", {WR, busy, done, flag_z, flag_c, flag_v}); end
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        issue(3'b000, 4'd2, 4'd4);
        wait_done(0, lat, wrs, wd, wa, bc);
        n_cmp++; if (lat !== 3 || wd !== 16'h0001) begin n_bad++; $display("FAIL rst_mul_restart got %0d/%h want 3/0001", lat, wd); end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_mul();
        test_illegal();
        test_ignore();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
